fsm_step_controller: RTL and testbench

- Sequencing controller for the 3-bit up/down counter state machine and its 7-segment/LED output.
- Debounces raw push-buttons into single-cycle press events.
- Produces the step enable, replacing the fixed frequency divider with a programmable tick.
- Provides run/pause/single-step control, a direction level, and a one-cycle initial-state load pulse that drives the state register's set/reset.

---
 rtl/fsm_step_controller.sv | 182 ++++++++++++++++++
 tb/tb_fsm_step_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_step_controller.sv
// fsm_step_controller
//   Sequencing controller for a 3-bit up/down counter with 7-segment/LED
//   output. It debounces four raw push-buttons into single-cycle press
//   events and generates a programmable step tick. It also provides
//   run / pause / single-step control, a direction level, and a one-cycle
//   pulse that loads the initial state.
//
// Ports
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-high; clears all state immediately
//   run_btn   : raw button, start / toggle run-pause
//   step_btn  : raw button, single step while paused
//   dir_btn   : raw button, toggle count direction
//   init_btn  : raw button, reload initial state
//   div_sel   : tick period minus one (period = div_sel+1 clocks)
//   step_en   : one-cycle enable to the state register
//   load_init : one-cycle pulse loading the initial state
//   dir_down  : direction level to next-state logic (1 = count down)
//   run_led   : high while running
//   tick_led  : toggles on every step_en
module fsm_step_controller #(
  parameter int DIV_WIDTH  = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_btn,
  input  logic                 step_btn,
  input  logic                 dir_btn,
  input  logic                 init_btn,
  input  logic [DIV_WIDTH-1:0] div_sel,
  output logic                 step_en,
  output logic                 load_init,
  output logic                 dir_down,
  output logic                 run_led,
  output logic                 tick_led
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  // Button lanes: 0 run, 1 step, 2 dir, 3 init
  localparam int B_RUN  = 0;
  localparam int B_STEP = 1;
  localparam int B_DIR  = 2;
  localparam int B_INIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  logic [3:0]          raw;
  logic [3:0]          s1_q, s1_d;
  logic [3:0]          s2_q, s2_d;
  logic [3:0]          deb_q, deb_d;
  logic [3:0]          press_q, press_d;
  logic [3:0][DCW-1:0] deb_cnt_q, deb_cnt_d;

  state_t               state_q, state_d;
  logic                 ret_pause_q, ret_pause_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 dir_q, dir_d;
  logic                 tick_q, tick_d;

  logic init_p, run_p, step_p, dir_p;
  logic tick_due;
  logic step_c;

  assign raw = {init_btn, dir_btn, step_btn, run_btn};

  // Debounce: a level change is accepted only after DEB_CYCLES consecutive
  // synchronized samples disagree with the current debounced level. Only a
  // rising acceptance produces a press pulse.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    deb_d = deb_q;
    press_d = '0;
    deb_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i]   = s2_q[i];
          press_d[i] = s2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // Same-cycle presses resolve init > run > step; dir is independent.
  assign init_p   = press_q[B_INIT];
  assign run_p    = press_q[B_RUN] & ~init_p;
  assign step_p   = press_q[B_STEP] & ~press_q[B_RUN] & ~init_p;
  assign dir_p    = press_q[B_DIR];
  assign tick_due = (div_cnt_q >= div_sel);

  always_comb begin
    state_d     = state_q;
    ret_pause_d = ret_pause_q;
    div_cnt_d   = div_cnt_q;
    step_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_p) begin
          state_d     = LOAD;
          ret_pause_d = 1'b0;
        end
      end
      LOAD: begin
        div_cnt_d = '0;
        state_d   = ret_pause_q ? PAUSE : RUN;
      end
      RUN: begin
        if (init_p) begin
          state_d     = LOAD;
          ret_pause_d = 1'b0;
        end else begin
          // A pausing press still lets the due tick through but freezes
          // the divider so the resume picks up where it left off.
          step_c = tick_due;
          if (run_p) begin
            state_d = PAUSE;
          end else begin
            div_cnt_d = tick_due ? '0 : div_cnt_q + DIV_WIDTH'(1);
          end
        end
      end
      PAUSE: begin
        if (init_p) begin
          state_d     = LOAD;
          ret_pause_d = 1'b1;
        end else if (run_p) begin
          state_d = RUN;
        end else begin
          step_c = step_p;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dir_d  = dir_q ^ (dir_p & (state_q != IDLE));
  assign tick_d = tick_q ^ step_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      deb_q       <= '0;
      press_q     <= '0;
      deb_cnt_q   <= '0;
      state_q     <= IDLE;
      ret_pause_q <= 1'b0;
      div_cnt_q   <= '0;
      dir_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_q       <= deb_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      ret_pause_q <= ret_pause_d;
      div_cnt_q   <= div_cnt_d;
      dir_q       <= dir_d;
      tick_q      <= tick_d;
    end
  end

  assign step_en   = step_c;
  assign load_init = (state_q == LOAD);
  assign run_led   = (state_q == RUN);
  assign dir_down  = dir_q;
  assign tick_led  = tick_q;

endmodule

// File: tb/tb_fsm_step_controller.sv
// tb_fsm_step_controller
//   Self-checking bench for fsm_step_controller. A behavioural model tracks
//   the controller: debounce as a sliding window over synchronized samples,
//   modes as plain integers, and the divider as a count of cycles since the
//   last tick. Directed scenarios are followed by randomized button traffic
//   with occasional asynchronous resets.
module tb_fsm_step_controller;

  localparam int DIV_WIDTH  = 4;
  localparam int DEB_CYCLES = 3;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 run_btn = 1'b0;
  logic                 step_btn = 1'b0;
  logic                 dir_btn = 1'b0;
  logic                 init_btn = 1'b0;
  logic [DIV_WIDTH-1:0] div_sel = '0;
  logic                 step_en, load_init, dir_down, run_led, tick_led;

  fsm_step_controller #(.DIV_WIDTH(DIV_WIDTH), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .run_btn(run_btn), .step_btn(step_btn), .dir_btn(dir_btn), .init_btn(init_btn),
    .div_sel(div_sel),
    .step_en(step_en), .load_init(load_init), .dir_down(dir_down),
    .run_led(run_led), .tick_led(tick_led)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int          mode;
  bit          ret_pause;
  int          mcnt;
  bit          mdir, mtick;
  bit   [3:0]  p1, p2, deb, mpress;
  logic [31:0] hist [4];

  // Observation bookkeeping
  bit last_step, last_load, last_dir, last_run;
  int cnt_step, cnt_load;
  bit dir_at_step;

  function automatic void model_reset();
    mode = M_IDLE; ret_pause = 1'b0; mcnt = 0; mdir = 1'b0; mtick = 1'b0;
    p1 = '0; p2 = '0; deb = '0; mpress = '0;
    for (int b = 0; b < 4; b++) hist[b] = '0;
  endfunction

  function automatic bit model_step();
    bit ip, sp;
    ip = mpress[3];
    sp = mpress[1] && !mpress[0] && !ip;
    if (mode == M_RUN && !ip && mcnt >= int'(div_sel)) return 1'b1;
    if (mode == M_PAUSE && sp) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge(input bit [3:0] rawv);
    bit ip, rp, dp, st;
    bit [3:0] np;
    logic [31:0] mask;
    ip = mpress[3];
    rp = mpress[0] && !ip;
    dp = mpress[2];
    st = model_step();
    if (dp && mode != M_IDLE) mdir = !mdir;
    if (st) mtick = !mtick;
    case (mode)
      M_IDLE:  if (rp) begin mode = M_LOAD; ret_pause = 1'b0; end
      M_LOAD:  begin mcnt = 0; mode = ret_pause ? M_PAUSE : M_RUN; end
      M_RUN: begin
        if (ip) begin mode = M_LOAD; ret_pause = 1'b0; end
        else if (rp) mode = M_PAUSE;
        else mcnt = st ? 0 : mcnt + 1;
      end
      default: begin
        if (ip) begin mode = M_LOAD; ret_pause = 1'b1; end
        else if (rp) mode = M_RUN;
      end
    endcase
    // A button level is accepted once the last DEB_CYCLES synchronized
    // samples all disagree with the current accepted level.
    mask = (32'd1 << DEB_CYCLES) - 32'd1;
    np = '0;
    for (int b = 0; b < 4; b++) begin
      hist[b] = {hist[b][30:0], p2[b]};
      if ((hist[b] & mask) == (deb[b] ? 32'd0 : mask)) begin
        deb[b] = !deb[b];
        np[b] = deb[b];
      end
      p2[b] = p1[b];
      p1[b] = rawv[b];
    end
    mpress = np;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    bit [4:0] exp_o;
    #1;
    exp_o = {model_step(), mode == M_LOAD, mdir, mode == M_RUN, mtick};
    check("outs{step,load,dir,run,tick}",
          {27'd0, step_en, load_init, dir_down, run_led, tick_led}, {27'd0, exp_o});
    last_step = step_en; last_load = load_init; last_dir = dir_down; last_run = run_led;
    if (step_en) begin cnt_step++; dir_at_step = dir_down; end
    if (load_init) cnt_load++;
    @(posedge clock);
    model_edge({init_btn, dir_btn, step_btn, run_btn});
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("async_reset_outs", {27'd0, step_en, load_init, dir_down, run_led, tick_led}, 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Hold the buttons in mask for hold cycles, then release for gap cycles.
  task automatic press_btns(input bit [3:0] mask, input int hold, input int gap);
    {init_btn, dir_btn, step_btn, run_btn} = mask;
    for (int i = 0; i < hold; i++) cycle();
    {init_btn, dir_btn, step_btn, run_btn} = 4'b0000;
    for (int i = 0; i < gap; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int load_at, first_at, second_at, found;
    int hold_left [4];
    bit [3:0] lv;

    model_reset();
    @(negedge clock);
    #1 check("reset_outs", {27'd0, step_en, load_init, dir_down, run_led, tick_led}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Short and chattering presses must not register
    cnt_step = 0; cnt_load = 0;
    press_btns(4'b0001, 2, 8);
    for (int i = 0; i < 20; i++) begin run_btn = i[0]; cycle(); end
    run_btn = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("glitch_no_load", cnt_load, 0);
    check("glitch_idle_run", {31'd0, last_run}, 0);

    // Start with period 4; measure press latency and tick spacing
    div_sel = 4'd3;
    load_at = -1; first_at = -1; second_at = -1;
    for (int i = 0; i < 24; i++) begin
      run_btn = (i < 6);
      cycle();
      if (last_load && load_at < 0) load_at = i;
      if (last_step) begin
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    check("start_load_cycle", load_at, 6);
    check("first_tick_cycle", first_at, 10);
    check("second_tick_cycle", second_at, 14);

    // Pause, stay quiet, then single steps
    press_btns(4'b0001, 5, 6);
    cnt_step = 0;
    for (int i = 0; i < 50; i++) cycle();
    check("pause_quiet", cnt_step, 0);
    cnt_step = 0;
    for (int k = 0; k < 3; k++) press_btns(4'b0010, 5, 8);
    check("pause_three_steps", cnt_step, 3);
    press_btns(4'b0001, 5, 12);   // resume
    press_btns(4'b0001, 5, 6);    // pause again

    // init and step together while paused: load only, back to pause
    cnt_step = 0; cnt_load = 0;
    press_btns(4'b1010, 5, 8);
    check("init_step_no_step", cnt_step, 0);
    check("init_step_one_load", cnt_load, 1);
    check("init_returns_pause", {31'd0, last_run}, 0);

    // dir together with step: step sees the old direction
    cnt_step = 0; dir_at_step = 1'b1;
    press_btns(4'b0110, 5, 6);
    check("dir_step_count", cnt_step, 1);
    check("dir_old_at_step", {31'd0, dir_at_step}, 0);
    check("dir_toggled", {31'd0, last_dir}, 1);

    // Lower div_sel below the running count
    div_sel = 4'd9;
    press_btns(4'b0001, 5, 0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (mode == M_RUN && mcnt == 6) found = 1;
      else cycle();
    end
    check("reach_cnt6", found, 1);
    div_sel = 4'd2;
    cycle();
    check("lowered_div_tick", {31'd0, last_step}, 1);
    cnt_step = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("lowered_div_period", cnt_step, 2);

    // Asynchronous reset mid-run with dir_down=1, tick_led=1, button held
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (mode == M_RUN && mtick) found = 1;
      else cycle();
    end
    check("reach_tick_high", found, 1);
    #1 check("pre_reset_dir_tick", {30'd0, dir_down, tick_led}, 32'd3);
    run_btn = 1'b1;
    @(negedge clock);
    do_reset();
    load_at = -1;
    for (int i = 0; i < 16; i++) begin
      run_btn = (i < 8);
      cycle();
      if (last_load && load_at < 0) load_at = i;
    end
    check("held_through_reset_load", load_at, 6);

    // Randomized traffic against the model
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    lv = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          lv[b] = (b == 3) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          hold_left[b] = $urandom_range(1, 7);
        end
        hold_left[b]--;
      end
      {init_btn, dir_btn, step_btn, run_btn} = lv;
      if ($urandom_range(0, 15) == 0) div_sel = DIV_WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
